// File: rtl/stage3_pool_sched.sv
// Stage-3 pooling sequencer: replays the stored stage-2 feature map channel by
// channel into the pooling line buffer and audits the returned window count.
module stage3_pool_sched #(
    parameter int IN_SIZE   = 8,
    parameter int POOL_K    = 2,
    parameter int STRIDE    = 2,
    parameter int NUM_CH    = 3,
    parameter int DRAIN_MAX = 8,
    parameter int OUT_SIZE  = (IN_SIZE - POOL_K) / STRIDE + 1,
    parameter int ADDR_BW   = $clog2(NUM_CH * IN_SIZE * IN_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_start,
    input  logic                      i_stall,
    output logic                      o_rd_en,
    output logic [ADDR_BW-1:0]        o_rd_addr,
    output logic                      o_pix_valid,
    output logic                      o_lb_clear,
    input  logic                      i_window_valid,
    output logic [$clog2(NUM_CH)-1:0] o_ch_idx,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    localparam int PIX_PER_CH = IN_SIZE * IN_SIZE;
    localparam int WIN_PER_CH = OUT_SIZE * OUT_SIZE;
    localparam int PIX_BW     = $clog2(PIX_PER_CH);
    localparam int WIN_BW     = $clog2(WIN_PER_CH + 1);
    localparam int DRAIN_BW   = $clog2(DRAIN_MAX + 1);
    localparam int CH_BW      = $clog2(NUM_CH);

    localparam logic [PIX_BW-1:0]   LAST_PIX  = PIX_BW'(PIX_PER_CH - 1);
    localparam logic [WIN_BW-1:0]   WIN_FULL  = WIN_BW'(WIN_PER_CH);
    localparam logic [DRAIN_BW-1:0] DRAIN_LIM = DRAIN_BW'(DRAIN_MAX);
    localparam logic [CH_BW-1:0]    LAST_CH   = CH_BW'(NUM_CH - 1);
    localparam logic [ADDR_BW-1:0]  CH_STRIDE = ADDR_BW'(PIX_PER_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CH_BW-1:0]    ch;
    logic [PIX_BW-1:0]   pix_cnt;
    logic [WIN_BW-1:0]   win_cnt;
    logic [DRAIN_BW-1:0] drain_cnt;
    logic                err;
    logic                pix_vld_p1;

    logic rd_en;
    logic win_full;
    logic counting;
    logic drain_timeout;

    always_comb begin
        rd_en         = (state == S_STREAM) && !i_stall;
        win_full      = (win_cnt == WIN_FULL);
        counting      = (state == S_STREAM) || (state == S_DRAIN);
        drain_timeout = (drain_cnt == DRAIN_LIM) && !win_full;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (i_start) state_nx = S_CLEAR;
            S_CLEAR:  state_nx = S_STREAM;
            S_STREAM: if (rd_en && (pix_cnt == LAST_PIX)) state_nx = S_DRAIN;
            // A full window count wins over the timeout in the same cycle
            S_DRAIN:  if (win_full || (drain_cnt == DRAIN_LIM)) state_nx = S_NEXT;
            S_NEXT:   state_nx = (ch == LAST_CH) ? S_DONE : S_CLEAR;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ch         <= '0;
            pix_cnt    <= '0;
            win_cnt    <= '0;
            drain_cnt  <= '0;
            err        <= 1'b0;
            pix_vld_p1 <= 1'b0;
        end else begin
            state      <= state_nx;
            // RAM data lands one cycle after the read, so valid trails rd_en by one
            pix_vld_p1 <= rd_en;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        ch  <= '0;
                        err <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    pix_cnt <= '0;
                    win_cnt <= '0;
                end
                S_STREAM: begin
                    if (rd_en) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_PIX) drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_timeout) err <= 1'b1;
                end
                S_NEXT: begin
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                end
                default: ;
            endcase
            // Surplus windows saturate the count and flag the channel
            if (counting && i_window_valid) begin
                if (win_full) err <= 1'b1;
                else          win_cnt <= win_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_rd_en     = rd_en;
        o_rd_addr   = (state == S_STREAM) ? (ADDR_BW'(ch) * CH_STRIDE + ADDR_BW'(pix_cnt)) : '0;
        o_pix_valid = pix_vld_p1;
        o_lb_clear  = (state == S_CLEAR);
        o_ch_idx    = ch;
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_DONE);
        o_err       = err;
    end

endmodule

// File: tb/tb_stage3_pool_sched.sv
// Randomized bench for stage3_pool_sched with a pixel-counting line-buffer model
// and a frame-level scoreboard of addresses, pulses and window-count errors.
module tb_stage3_pool_sched;

    localparam int IN   = 8;
    localparam int K    = 2;
    localparam int S    = 2;
    localparam int NCH  = 3;
    localparam int DMAX = 8;
    localparam int OUTS = (IN - K) / S + 1;
    localparam int WPC  = OUTS * OUTS;
    localparam int PPC  = IN * IN;
    localparam int ABW  = $clog2(NCH * PPC);
    localparam int CBW  = $clog2(NCH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic           i_start;
    logic           i_stall;
    logic           i_window_valid;
    logic           o_rd_en;
    logic [ABW-1:0] o_rd_addr;
    logic           o_pix_valid;
    logic           o_lb_clear;
    logic [CBW-1:0] o_ch_idx;
    logic           o_busy;
    logic           o_done;
    logic           o_err;

    stage3_pool_sched #(
        .IN_SIZE(IN), .POOL_K(K), .STRIDE(S), .NUM_CH(NCH), .DRAIN_MAX(DMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_stall(i_stall),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_pix_valid(o_pix_valid),
        .o_lb_clear(o_lb_clear), .i_window_valid(i_window_valid),
        .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // frame configuration
    bit cfg_rnd;
    int cfg_stall_at, cfg_hold_ch, cfg_extra_ch, cfg_restart_at;
    bit cfg_abort;

    // reference-model state
    int tick_no, start_tick, exp_addr, clr_cnt, pv_cnt, done_cnt;
    int lb_ch, lb_pix, lb_win, win_q, stall_left, last_pv_tick;
    bit prev_rd_en, stall_done, restart_done, abort_arm, aborted, start_req, targ_stall;

    task automatic monitor();
        int x, y;
        check_eq("pix_vld_follow", o_pix_valid, prev_rd_en);
        if (i_stall) check_eq("rd_en_stalled", o_rd_en, 0);
        if (targ_stall) check_eq("stall_addr_hold", o_rd_addr, cfg_stall_at);
        if (o_lb_clear) begin
            if (clr_cnt == 0) begin
                check_eq("err_clr_on_start", o_err, 0);
                check_eq("clear_lat", tick_no - start_tick, 1);
            end
            check_eq("clear_at_ch_start", exp_addr, clr_cnt * PPC);
            clr_cnt++;
            lb_ch++;
            lb_pix = 0;
            lb_win = 0;
        end
        if (o_rd_en) begin
            if (exp_addr == 0 && !cfg_rnd) check_eq("first_rd_lat", tick_no - start_tick, 2);
            check_eq("rd_addr", o_rd_addr, exp_addr);
            check_eq("ch_idx", o_ch_idx, exp_addr / PPC);
            check_eq("busy_streaming", o_busy, 1);
            exp_addr++;
            if (cfg_abort && exp_addr == 2 * PPC) abort_arm = 1;
        end
        if (o_pix_valid) begin
            if (pv_cnt == cfg_stall_at) check_eq("stall_gap", tick_no - last_pv_tick - 1, 5);
            last_pv_tick = tick_no;
            pv_cnt++;
            x = lb_pix % IN;
            y = lb_pix / IN;
            if (x >= K - 1 && (x - (K - 1)) % S == 0 && y >= K - 1 && (y - (K - 1)) % S == 0) begin
                lb_win++;
                if (!(lb_ch == cfg_hold_ch && lb_win == WPC))
                    win_q += (lb_ch == cfg_extra_ch && lb_win == WPC) ? 2 : 1;
            end
            lb_pix++;
        end
        if (o_done) done_cnt++;
        prev_rd_en = o_rd_en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        i_start = 1'b0;
        if (start_req) begin
            i_start    = 1'b1;
            start_req  = 0;
            start_tick = tick_no;
        end else if (exp_addr == cfg_restart_at && !restart_done) begin
            i_start      = 1'b1;
            restart_done = 1;
        end
        i_window_valid = (win_q > 0);
        if (win_q > 0) win_q--;
        if (!stall_done && exp_addr == cfg_stall_at) begin
            stall_left = 5;
            stall_done = 1;
        end
        targ_stall = (stall_left > 0);
        if (stall_left > 0) begin
            i_stall = 1'b1;
            stall_left--;
        end else begin
            i_stall = cfg_rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (abort_arm) begin
            reset_n   = 1'b0;
            abort_arm = 0;
            aborted   = 1;
            #1;
            check_eq("abort_busy", o_busy, 0);
            check_eq("abort_rd_en", o_rd_en, 0);
            check_eq("abort_pix_valid", o_pix_valid, 0);
            check_eq("abort_done", o_done, 0);
        end
        @(negedge clk);
        if (reset_n) monitor();
    endtask

    task automatic run_frame(input bit rnd, input int stall_at, input int hold_ch,
                             input int extra_ch, input int restart_at, input bit abort,
                             input bit exp_err);
        bit finished;
        cfg_rnd = rnd; cfg_stall_at = stall_at; cfg_hold_ch = hold_ch;
        cfg_extra_ch = extra_ch; cfg_restart_at = restart_at; cfg_abort = abort;
        exp_addr = 0; clr_cnt = 0; pv_cnt = 0; done_cnt = 0;
        lb_ch = -1; lb_pix = 0; lb_win = 0; win_q = 0; stall_left = 0; last_pv_tick = 0;
        stall_done = 0; restart_done = 0; abort_arm = 0; aborted = 0; targ_stall = 0;
        start_req = 1;
        finished = 0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            tick();
            if (aborted || done_cnt > 0) finished = 1;
        end
        if (!finished) check_eq("frame_timeout", 0, 1);
        if (aborted) begin
            check_eq("no_done_on_abort", done_cnt, 0);
            tick();
            tick();
            check_eq("reset_ch_idx", o_ch_idx, 0);
            check_eq("reset_err", o_err, 0);
            @(posedge clk);
            #1;
            reset_n    = 1'b1;
            prev_rd_en = 0;
            aborted    = 0;
        end else if (finished) begin
            check_eq("done_pulses", done_cnt, 1);
            check_eq("err_final", o_err, exp_err);
            check_eq("clear_pulses", clr_cnt, NCH);
            check_eq("pix_valid_total", pv_cnt, NCH * PPC);
            check_eq("addr_total", exp_addr, NCH * PPC);
            tick();
            check_eq("done_one_cycle", o_done, 0);
            check_eq("idle_after_done", o_busy, 0);
            check_eq("err_sticky", o_err, exp_err);
        end
    endtask

    initial begin
        reset_n = 1'b0; i_start = 1'b0; i_stall = 1'b0; i_window_valid = 1'b0;
        tick_no = 0; start_tick = 0; prev_rd_en = 0; win_q = 0;
        cfg_rnd = 0; cfg_stall_at = -1; cfg_hold_ch = -1; cfg_extra_ch = -1;
        cfg_restart_at = -1; cfg_abort = 0;
        exp_addr = 0; clr_cnt = 0; pv_cnt = 0; done_cnt = 0; lb_ch = -1; lb_pix = 0;
        lb_win = 0; stall_left = 0; last_pv_tick = 0; stall_done = 0; restart_done = 0;
        abort_arm = 0; aborted = 0; start_req = 0; targ_stall = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rd_en", o_rd_en, 0);
        check_eq("rst_rd_addr", o_rd_addr, 0);
        check_eq("rst_pix_valid", o_pix_valid, 0);
        check_eq("rst_lb_clear", o_lb_clear, 0);
        check_eq("rst_ch_idx", o_ch_idx, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_frame(0, -1, -1, -1, -1, 0, 0);          // clean frame
        run_frame(0, PPC + 20, -1, -1, -1, 0, 0);    // 5-cycle stall at ch1 pixel 20
        run_frame(1, -1, 0, -1, -1, 0, 1);           // ch0 short one window
        run_frame(1, -1, -1, -1, 100, 0, 0);         // restart ignored, err cleared
        run_frame(1, -1, -1, 2, -1, 0, 1);           // ch2 one surplus window
        run_frame(1, -1, -1, -1, -1, 1, 0);          // reset during ch1 drain
        run_frame(0, -1, -1, -1, -1, 0, 0);          // clean frame after reset
        for (int r = 0; r < 3; r++) begin
            int sel, h, e;
            sel = $urandom_range(0, 2);
            h = (sel == 1) ? int'($urandom_range(0, NCH - 1)) : -1;
            e = (sel == 2) ? int'($urandom_range(0, NCH - 1)) : -1;
            run_frame(1, -1, h, e, -1, 0, sel != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
